// File: rtl/rv_trace_tx.sv
// rv_trace_tx: retire-trace transmitter.
// Captures one record per retired instruction, queues records in a small
// FIFO and serializes them LSB-first as a byte stream over valid/ready.
// Record: HDR, PC[4], INSTR[4], [RDATA[4]], [MADDR[4], MDATA[4]], [CSUM].
// Optional feature macro: RV_TRACE_TX_CHECKSUM_EN appends a CSUM byte equal
// to the XOR of every preceding byte of the record.

module rv_trace_tx #(
   parameter int IADDR_SPACE_BITS = 32,
   parameter int FIFO_DEPTH       = 8
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_retire_valid,
   input  logic [IADDR_SPACE_BITS-1:1]   i_pc,
   input  logic [31:0]                   i_instr,
   input  logic                          i_reg_write,
   input  logic [31:0]                   i_reg_data,
   input  logic                          i_mem_read,
   input  logic                          i_mem_write,
   input  logic [31:0]                   i_mem_addr,
   input  logic [31:0]                   i_mem_data,
   output logic [7:0]                    o_tx_data,
   output logic                          o_tx_valid,
   input  logic                          i_tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_overflow,
   output logic [7:0]                    o_drop_cnt,
   output logic                          o_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   // Serializer states; one state per record field.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_HDR   = 3'd1;
   localparam logic [2:0] ST_PC    = 3'd2;
   localparam logic [2:0] ST_INSTR = 3'd3;
   localparam logic [2:0] ST_RDATA = 3'd4;
   localparam logic [2:0] ST_MADDR = 3'd5;
   localparam logic [2:0] ST_MDATA = 3'd6;
`ifdef RV_TRACE_TX_CHECKSUM_EN
   localparam logic [2:0] ST_CSUM  = 3'd7;
`endif

   // One captured retirement. mem_read is already masked when the
   // instruction also reports a store, so only the store flag survives.
   typedef struct packed {
      logic        lost;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] rdata;
      logic [31:0] maddr;
      logic [31:0] mdata;
   } rec_t;

   // FIFO storage and bookkeeping.
   rec_t          mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;

   // Drop tracking.
   logic          lost_q, lost_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;

   // Serializer.
   logic [2:0]    state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   rec_t          hold_q;
`ifdef RV_TRACE_TX_CHECKSUM_EN
   logic [7:0]    csum_q, csum_d;
`endif

   logic [31:0]   pc_ext;
   rec_t          rec_in;
   logic          full;
   logic          push;
   logic          drop;
   logic          pop;
   logic          accept;
   logic          tx_valid;
   logic [7:0]    tx_byte;
   logic [7:0]    hdr_byte;
   logic          hold_mem;
   logic          fields_done;
   logic          rec_done;

   // Select byte i (little-endian) of a 32-bit field.
   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
      return w[8*i +: 8];
   endfunction

   // Assemble the incoming record; PC is zero-extended with bit 0 forced low.
   // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
   always_comb begin
      pc_ext                         = '0;
      pc_ext[IADDR_SPACE_BITS-1:1]   = i_pc;
      rec_in.lost                    = lost_q;
      rec_in.reg_write               = i_reg_write;
      rec_in.mem_read                = i_mem_read & ~i_mem_write;
      rec_in.mem_write               = i_mem_write;
      rec_in.pc                      = pc_ext;
      rec_in.instr                   = i_instr;
      rec_in.rdata                   = i_reg_data;
      rec_in.maddr                   = i_mem_addr;
      rec_in.mdata                   = i_mem_data;
   end

   // Full is judged on the registered level: a pop in the same cycle does not make room.
   assign full     = (level_q == LW'(FIFO_DEPTH));
   assign push     = i_retire_valid & ~full;
   assign drop     = i_retire_valid &  full;
   assign tx_valid = (state_q != ST_IDLE);
   assign accept   = tx_valid & i_tx_ready;
   assign hold_mem = hold_q.mem_read | hold_q.mem_write;
   assign hdr_byte = {1'b1, hold_q.lost, hold_q.reg_write, hold_q.mem_read,
                      hold_q.mem_write, 3'b000};

   // Byte currently presented to the sink; it depends only on registered
   // state, so it stays put until the sink accepts it.
   always_comb begin
      tx_byte = 8'h00;
      case (state_q)
         ST_HDR:   tx_byte = hdr_byte;
         ST_PC:    tx_byte = byte_of(hold_q.pc,    idx_q);
         ST_INSTR: tx_byte = byte_of(hold_q.instr, idx_q);
         ST_RDATA: tx_byte = byte_of(hold_q.rdata, idx_q);
         ST_MADDR: tx_byte = byte_of(hold_q.maddr, idx_q);
         ST_MDATA: tx_byte = byte_of(hold_q.mdata, idx_q);
`ifdef RV_TRACE_TX_CHECKSUM_EN
         ST_CSUM:  tx_byte = csum_q;
`endif
         default:  tx_byte = 8'h00;
      endcase
   end

   // Serializer next state: walk the fields present in the held record,
   // four bytes per field, then either stop or chain into the next record.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      fields_done = 1'b0;
      rec_done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (level_q != '0) state_d = ST_HDR;
         end
         ST_HDR: begin
            if (accept) state_d = ST_PC;
         end
         ST_PC: begin
            if (accept) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = ST_INSTR;
            end
         end
         ST_INSTR: begin
            if (accept) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  if (hold_q.reg_write) state_d = ST_RDATA;
                  else if (hold_mem)    state_d = ST_MADDR;
                  else                  fields_done = 1'b1;
               end
            end
         end
         ST_RDATA: begin
            if (accept) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  if (hold_mem) state_d = ST_MADDR;
                  else          fields_done = 1'b1;
               end
            end
         end
         ST_MADDR: begin
            if (accept) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = ST_MDATA;
            end
         end
         ST_MDATA: begin
            if (accept) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) fields_done = 1'b1;
            end
         end
`ifdef RV_TRACE_TX_CHECKSUM_EN
         ST_CSUM: begin
            if (accept) rec_done = 1'b1;
         end
`endif
         default: state_d = ST_IDLE;
      endcase

`ifdef RV_TRACE_TX_CHECKSUM_EN
      if (fields_done) state_d = ST_CSUM;
`else
      rec_done = fields_done;
`endif
      // Chain straight into the next header when a record is waiting.
      if (rec_done) state_d = (level_q != '0) ? ST_HDR : ST_IDLE;
   end

   // A record leaves the FIFO whenever the serializer is about to start a header.
   assign pop = (level_q != '0) & ((state_q == ST_IDLE) | rec_done);

   // FIFO pointer/level and drop bookkeeping next state.
   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d    = level_q + LW'(push) - LW'(pop);
      lost_d     = lost_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         lost_d     = 1'b1;
         overflow_d = 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end else if (push) begin
         lost_d = 1'b0;
      end
   end

   // Control registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         lost_q     <= 1'b0;
         overflow_q <= 1'b0;
         drop_cnt_q <= 8'h00;
         state_q    <= ST_IDLE;
         idx_q      <= 2'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         lost_q     <= lost_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         state_q    <= state_d;
         idx_q      <= idx_d;
      end
   end

   // Record payload: FIFO write and hand-off into the serializer holding register.
   // NOTE: payload storage has no reset; level and state decide what is valid, so stale contents are never emitted.
   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q] <= rec_in;
      if (pop)  hold_q          <= mem_q[rd_ptr_q];
   end

`ifdef RV_TRACE_TX_CHECKSUM_EN
   // Running XOR of the bytes sent so far; restarts when a new record is loaded.
   always_comb begin
      csum_d = csum_q;
      if (pop)         csum_d = 8'h00;
      else if (accept) csum_d = csum_q ^ tx_byte;
   end

   // Checksum accumulator register.
   always_ff @(posedge i_clk) begin
      if (i_reset) csum_q <= 8'h00;
      else         csum_q <= csum_d;
   end
`endif

   assign o_tx_data    = tx_byte;
   assign o_tx_valid   = tx_valid;
   assign o_fifo_level = level_q;
   assign o_overflow   = overflow_q;
   assign o_drop_cnt   = drop_cnt_q;
   assign o_busy       = tx_valid | (level_q != '0);

endmodule

// File: tb/tb_rv_trace_tx.sv
// tb_rv_trace_tx: scoreboard bench for rv_trace_tx (FIFO_DEPTH=4).
// Stimulus pushes hand-derived byte streams into a queue; a monitor thread
// compares every accepted byte and checks stability under backpressure.

module tb_rv_trace_tx;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          retire_valid;
   logic [31:1]   pc;
   logic [31:0]   instr;
   logic          reg_write;
   logic [31:0]   reg_data;
   logic          mem_read;
   logic          mem_write;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_data;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic [LW-1:0] fifo_level;
   logic          overflow;
   logic [7:0]    drop_cnt;
   logic          busy;

   logic [7:0]    exp_q [$];
   int            tests = 0;
   int            fails = 0;
   int            xfers = 0;

   // Hand-computed streams from the reference cases.
   logic [7:0] c_addi [$] = '{8'hA0, 8'h80, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                              8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
   logic [7:0] c_sw   [$] = '{8'h88, 8'h84, 8'h00, 8'h00, 8'h00, 8'h23, 8'h20,
                              8'hA1, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF,
                              8'hBE, 8'hAD, 8'hDE};

   always #5 clk = ~clk;

   rv_trace_tx #(
      .IADDR_SPACE_BITS (32),
      .FIFO_DEPTH       (DEPTH)
   ) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_retire_valid (retire_valid),
      .i_pc           (pc),
      .i_instr        (instr),
      .i_reg_write    (reg_write),
      .i_reg_data     (reg_data),
      .i_mem_read     (mem_read),
      .i_mem_write    (mem_write),
      .i_mem_addr     (mem_addr),
      .i_mem_data     (mem_data),
      .o_tx_data      (tx_data),
      .o_tx_valid     (tx_valid),
      .i_tx_ready     (tx_ready),
      .o_fifo_level   (fifo_level),
      .o_overflow     (overflow),
      .o_drop_cnt     (drop_cnt),
      .o_busy         (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Queue a record's bytes, appending the checksum when that build option is on.
   task automatic push_bytes(input logic [7:0] b [$]);
`ifdef RV_TRACE_TX_CHECKSUM_EN
      logic [7:0] x = 8'h00;
      foreach (b[i]) begin
         exp_q.push_back(b[i]);
         x ^= b[i];
      end
      exp_q.push_back(x);
`else
      foreach (b[i]) exp_q.push_back(b[i]);
`endif
   endtask

   // Build the expected record bytes for a retirement.
   task automatic push_rec(input logic [31:0] p, input logic [31:0] ins, input logic rw,
                           input logic [31:0] rd, input logic mr, input logic mw,
                           input logic [31:0] ma, input logic [31:0] md, input logic lost);
      logic [7:0] b [$];
      b.push_back({1'b1, lost, rw, mr & ~mw, mw, 3'b000});
      for (int i = 0; i < 4; i++) b.push_back(p[8*i +: 8]);
      for (int i = 0; i < 4; i++) b.push_back(ins[8*i +: 8]);
      if (rw) for (int i = 0; i < 4; i++) b.push_back(rd[8*i +: 8]);
      if (mr | mw) begin
         for (int i = 0; i < 4; i++) b.push_back(ma[8*i +: 8]);
         for (int i = 0; i < 4; i++) b.push_back(md[8*i +: 8]);
      end
      push_bytes(b);
   endtask

   task automatic drive(input logic [31:0] p, input logic [31:0] ins, input logic rw,
                        input logic [31:0] rd, input logic mr, input logic mw,
                        input logic [31:0] ma, input logic [31:0] md);
      retire_valid = 1'b1;
      pc           = p[31:1];
      instr        = ins;
      reg_write    = rw;
      reg_data     = rd;
      mem_read     = mr;
      mem_write    = mw;
      mem_addr     = ma;
      mem_data     = md;
   endtask

   // One-cycle retire pulse, driven just after a rising edge.
   task automatic retire(input logic [31:0] p, input logic [31:0] ins, input logic rw,
                         input logic [31:0] rd, input logic mr, input logic mw,
                         input logic [31:0] ma, input logic [31:0] md);
      @(posedge clk); #1;
      drive(p, ins, rw, rd, mr, mw, ma, md);
      @(posedge clk); #1;
      retire_valid = 1'b0;
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!tx_valid && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (!tx_valid) check("wait_valid_timeout", tx_valid, 1);
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_all_bytes"}, exp_q.size(), 0);
      check({name, "_idle"}, busy, 0);
   endtask

   // Scoreboard monitor: compares each accepted byte, checks hold under stall.
   task automatic monitor();
      logic [7:0] held   = 8'h00;
      logic       held_v = 1'b0;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_v = 1'b0;
         end else begin
            if (held_v) begin
               check("hold_valid", tx_valid, 1);
               check("hold_data", tx_data, held);
            end
            if (tx_valid && tx_ready) begin
               xfers++;
               check("byte_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("stream_byte", tx_data, e);
               end
               held_v = 1'b0;
            end else if (tx_valid) begin
               held   = tx_data;
               held_v = 1'b1;
            end else begin
               held_v = 1'b0;
            end
         end
      end
   endtask

   initial begin
      int base;
      int gaps;
      int n;

      rst          = 1'b1;
      retire_valid = 1'b0;
      pc           = '0;
      instr        = '0;
      reg_write    = 1'b0;
      reg_data     = '0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_addr     = '0;
      mem_data     = '0;
      tx_ready     = 1'b0;

      fork
         monitor();
      join_none

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", tx_valid, 0);
      check("rst_data", tx_data, 0);
      check("rst_level", fifo_level, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;

      // Case 1: addi, header two cycles after retire.
      tx_ready = 1'b1;
      @(posedge clk); #1;
      drive(32'h80, 32'h00100093, 1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
      push_bytes(c_addi);
      @(posedge clk); #1;
      retire_valid = 1'b0;
      check("lat_n1_valid", tx_valid, 0);
      check("lat_n1_level", fifo_level, 1);
      check("lat_n1_busy", busy, 1);
      @(posedge clk); #1;
      check("lat_n2_valid", tx_valid, 1);
      check("lat_n2_hdr", tx_data, 8'hA0);
      check("lat_n2_level", fifo_level, 0);
      drain("addi", 100);

      // Case 2: store record with address and data.
      push_bytes(c_sw);
      retire(32'h84, 32'h00A12023, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000, 32'hDEADBEEF);
      drain("sw", 100);

      // Case 2b: load and store flags both set keep only the store flag.
      push_rec(32'h90, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 32'h12345678, 1'b0);
      retire(32'h90, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'h12345678);
      drain("ld_st", 100);

      // Case 3: backpressure on PC byte 2 for five cycles.
      push_bytes(c_addi);
      retire(32'h80, 32'h00100093, 1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
      wait_valid(20);
      repeat (3) @(posedge clk);
      #1;
      tx_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("bp_valid", tx_valid, 1);
      check("bp_level", fifo_level, 0);
      tx_ready = 1'b1;
      drain("bp", 100);

      // Case 4: overflow with the sink stalled.
      tx_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         if (i == 6) check("ovf_drop1", drop_cnt, 1);
         drive(32'h100 + 32'(4*i), 32'h13, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
         if (i < 5) push_rec(32'h100 + 32'(4*i), 32'h13, 1'b0, 32'h0, 1'b0, 1'b0,
                             32'h0, 32'h0, 1'b0);
      end
      @(posedge clk); #1;
      retire_valid = 1'b0;
      check("ovf_level", fifo_level, 4);
      check("ovf_drop2", drop_cnt, 2);
      check("ovf_flag", overflow, 1);
      check("ovf_busy", busy, 1);
      check("ovf_hdr_held", tx_data, 8'h80);
      tx_ready = 1'b1;
      drain("ovf", 400);
      // Next accepted record carries lost=1, the one after it lost=0.
      push_rec(32'h200, 32'h13, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      push_rec(32'h204, 32'h13, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(posedge clk); #1;
      drive(32'h200, 32'h13, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      drive(32'h204, 32'h13, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      retire_valid = 1'b0;
      drain("lost", 100);
      check("ovf_sticky", overflow, 1);
      check("ovf_cnt_kept", drop_cnt, 2);

      // Case 5: reset in the middle of a record.
      tx_ready = 1'b0;
      push_bytes(c_addi);
      retire(32'h80, 32'h00100093, 1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
      wait_valid(20);
      base     = xfers;
      tx_ready = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      tx_ready = 1'b0;
      check("mid_xfers", xfers - base, 7);
      check("mid_instr2", tx_data, 8'h10);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_valid", tx_valid, 0);
      check("mid_rst_level", fifo_level, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_overflow", overflow, 0);
      tx_ready = 1'b1;
      push_bytes(c_sw);
      retire(32'h84, 32'h00A12023, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000, 32'hDEADBEEF);
      drain("post_rst", 100);

      // Case 6: three back-to-back retires stream without idle gaps.
      push_bytes(c_addi);
      push_bytes(c_sw);
      push_rec(32'h88, 32'h13, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(posedge clk); #1;
      drive(32'h80, 32'h00100093, 1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      drive(32'h84, 32'h00A12023, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000, 32'hDEADBEEF);
      @(posedge clk); #1;
      drive(32'h88, 32'h13, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      retire_valid = 1'b0;
      wait_valid(20);
      gaps = 0;
      n    = 0;
      while (busy && n < 200) begin
         if (!tx_valid) gaps++;
         @(posedge clk); #1;
         n++;
      end
      check("b2b_gaps", gaps, 0);
      drain("b2b", 100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
